// File: rtl/aes_block_buffer_pkg.sv
// rtl/aes_block_buffer_pkg.sv - shared types and widths for the AES block buffer
// Optional drop counter width is used only when AES_BUF_DROP_CNT_EN is defined.
package aes_buf_pkg;

    localparam int BLK_W  = 128;
    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/aes_block_buffer_if.sv
// rtl/aes_block_buffer_if.sv - sample-in / AES-core-out bus of the block buffer
// drop_cnt exists only when AES_BUF_DROP_CNT_EN is defined.
interface aes_block_buffer_if
    import aes_buf_pkg::*;
#(
    parameter int ADDR_W = 2
);
    logic [BLK_W-1:0]  data128;
    logic              data128_en;
    logic [BLK_W-1:0]  aes_din;
    logic              aes_start;
    logic              aes_busy;
    logic              aes_done;
    logic [ADDR_W:0]   fifo_level;
    logic              overflow;
    logic              timeout_err;
    logic              clr_err;
`ifdef AES_BUF_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt;
`endif

    modport master (
        output data128, data128_en, aes_busy, aes_done, clr_err,
`ifdef AES_BUF_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  aes_din, aes_start, fifo_level, overflow, timeout_err
    );

    modport slave (
        input  data128, data128_en, aes_busy, aes_done, clr_err,
`ifdef AES_BUF_DROP_CNT_EN
        output drop_cnt,
`endif
        output aes_din, aes_start, fifo_level, overflow, timeout_err
    );

endinterface

// File: rtl/aes_block_buffer_blk_fifo.sv
// rtl/aes_block_buffer_blk_fifo.sv - synchronous block FIFO with extra-MSB pointers
module blk_fifo
    import aes_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [BLK_W-1:0] din,
    output logic [BLK_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [ADDR_W:0]  level
);

    logic [BLK_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    // Full when the pointers address the same slot but sit on different laps.
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}};
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/aes_block_buffer.sv
// rtl/aes_block_buffer.sv - queues ADC blocks and feeds them to the AES core with a watchdog
// Optional saturating drop counter enabled by AES_BUF_DROP_CNT_EN.
module aes_block_buffer
    import aes_buf_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic            sclk,
    input  logic            rst_n,
    aes_block_buffer_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic             launch;
    logic             expire;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;
    logic [BLK_W-1:0] fifo_dout;
    logic [BLK_W-1:0] din_q;
    logic [TO_W-1:0]  wd_cnt;
    logic [TO_W-1:0]  wd_next;

    // Drop decision uses the pre-edge full flag even if a launch pops this cycle.
    assign push = bus.data128_en && !full;
    assign drop = bus.data128_en && full;

    blk_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk   (sclk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (launch),
        .din   (bus.data128),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (bus.fifo_level)
    );

    assign wd_next = wd_cnt + TO_W'(1);
    assign expire  = (state == WAIT) && (wd_next == TO_W'(TIMEOUT - 1));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty && !bus.aes_busy) state_nx = LAUNCH;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (bus.aes_done || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        launch = 1'b0;
        case (state)
            LAUNCH:  launch = 1'b1;
            default: launch = 1'b0;
        endcase
    end

    // The head is shown directly during launch so aes_din is valid with aes_start.
    assign bus.aes_start = launch;
    assign bus.aes_din   = launch ? fifo_dout : din_q;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            din_q  <= '0;
            wd_cnt <= '0;
        end else if (launch) begin
            din_q  <= fifo_dout;
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_next;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow    <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else if (bus.clr_err) begin
            bus.overflow    <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            if (drop)                      bus.overflow    <= 1'b1;
            if (expire && !bus.aes_done)   bus.timeout_err <= 1'b1;
        end
    end

`ifdef AES_BUF_DROP_CNT_EN
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n)                             bus.drop_cnt <= '0;
        else if (bus.clr_err)                   bus.drop_cnt <= '0;
        else if (drop && (bus.drop_cnt != '1))  bus.drop_cnt <= bus.drop_cnt + DROP_W'(1);
    end
`endif

endmodule

// File: tb/tb_aes_block_buffer.sv
// tb/tb_aes_block_buffer.sv - directed self-checking bench for aes_block_buffer
// Drop counter checks are compiled in when AES_BUF_DROP_CNT_EN is defined.
module tb_aes_block_buffer;

    localparam int TIMEOUT = 1024;
    localparam logic [127:0] BLK_X = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic sclk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [127:0] blk [5];

    aes_block_buffer_if #(.ADDR_W(2)) bus ();

    aes_block_buffer #(
        .DEPTH(4), .ADDR_W(2), .TIMEOUT(TIMEOUT), .TO_W(11)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic fill_blocks(input int n, input logic [31:0] seed);
        for (int i = 0; i < n; i++) begin
            blk[i] = {4{32'(seed + 32'(i))}};
            bus.data128    = blk[i];
            bus.data128_en = 1'b1;
            step();
            bus.data128_en = 1'b0;
        end
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (bus.aes_start) break;
            step();
        end
        chk(tag, 128'(bus.aes_start), 128'(1));
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            wait_start({tag, "_start"});
            chk({tag, "_din"}, bus.aes_din, blk[i]);
            step();
            bus.aes_done = 1'b1;
            step();
            bus.aes_done = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.data128 = '0;
        bus.data128_en = 1'b0;
        bus.aes_busy = 1'b0;
        bus.aes_done = 1'b0;
        bus.clr_err = 1'b0;
        step();
        step();
        chk("rst_din",   bus.aes_din, 128'(0));
        chk("rst_start", 128'(bus.aes_start), 128'(0));
        chk("rst_level", 128'(bus.fifo_level), 128'(0));
        chk("rst_ovf",   128'(bus.overflow), 128'(0));
        chk("rst_to",    128'(bus.timeout_err), 128'(0));
        rst_n = 1'b1;
        step();

        // Single block: strobe in N, launch in N+2.
        bus.data128 = BLK_X;
        bus.data128_en = 1'b1;
        step();
        bus.data128_en = 1'b0;
        chk("single_lvl1",   128'(bus.fifo_level), 128'(1));
        chk("single_nostart", 128'(bus.aes_start), 128'(0));
        step();
        chk("single_start", 128'(bus.aes_start), 128'(1));
        chk("single_din",   bus.aes_din, BLK_X);
        step();
        chk("single_lvl0",  128'(bus.fifo_level), 128'(0));
        chk("single_pulse", 128'(bus.aes_start), 128'(0));
        chk("single_hold",  bus.aes_din, BLK_X);
        bus.aes_done = 1'b1;
        step();
        bus.aes_done = 1'b0;

        // Burst of 4 while busy, then a 5th that must be dropped.
        bus.aes_busy = 1'b1;
        fill_blocks(4, 32'hB10C_0000);
        chk("burst_lvl4", 128'(bus.fifo_level), 128'(4));
        chk("burst_noovf", 128'(bus.overflow), 128'(0));
        bus.data128 = 128'hDEAD;
        bus.data128_en = 1'b1;
        step();
        bus.data128_en = 1'b0;
        chk("ovf_set", 128'(bus.overflow), 128'(1));
        chk("ovf_lvl", 128'(bus.fifo_level), 128'(4));
`ifdef AES_BUF_DROP_CNT_EN
        chk("ovf_cnt", 128'(bus.drop_cnt), 128'(1));
`endif
        chk("busy_hold", 128'(bus.aes_start), 128'(0));
        bus.aes_busy = 1'b0;
        drain(4, "burst");
        chk("burst_empty", 128'(bus.fifo_level), 128'(0));

        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("clr_ovf", 128'(bus.overflow), 128'(0));
`ifdef AES_BUF_DROP_CNT_EN
        chk("clr_cnt", 128'(bus.drop_cnt), 128'(0));
`endif

        // clr_err wins over a same-cycle drop.
        bus.aes_busy = 1'b1;
        fill_blocks(4, 32'hC0DE_0010);
        bus.data128 = 128'hBEEF;
        bus.data128_en = 1'b1;
        bus.clr_err = 1'b1;
        step();
        bus.data128_en = 1'b0;
        bus.clr_err = 1'b0;
        chk("clrprio_ovf", 128'(bus.overflow), 128'(0));
        chk("clrprio_lvl", 128'(bus.fifo_level), 128'(4));
`ifdef AES_BUF_DROP_CNT_EN
        chk("clrprio_cnt", 128'(bus.drop_cnt), 128'(0));
`endif
        bus.aes_busy = 1'b0;
        drain(4, "clrprio");

        // Timeout: no done for the first launch, next block follows.
        bus.aes_busy = 1'b1;
        fill_blocks(2, 32'h7100_0000);
        bus.aes_busy = 1'b0;
        wait_start("to_start0");
        chk("to_din0", bus.aes_din, blk[0]);
        repeat (TIMEOUT - 1) step();
        chk("to_before", 128'(bus.timeout_err), 128'(0));
        step();
        chk("to_set", 128'(bus.timeout_err), 128'(1));
        step();
        chk("to_next_start", 128'(bus.aes_start), 128'(1));
        chk("to_next_din",   bus.aes_din, blk[1]);

        // Done in the final watchdog cycle counts as success.
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("to_clr", 128'(bus.timeout_err), 128'(0));
        repeat (TIMEOUT - 2) step();
        bus.aes_done = 1'b1;
        step();
        bus.aes_done = 1'b0;
        chk("edge_noto", 128'(bus.timeout_err), 128'(0));
        step();
        chk("edge_noto2", 128'(bus.timeout_err), 128'(0));
        chk("edge_idle",  128'(bus.aes_start), 128'(0));

        // Asynchronous reset during WAIT.
        bus.aes_busy = 1'b1;
        fill_blocks(5, 32'hA5A5_0100);
        chk("arst_pre_ovf", 128'(bus.overflow), 128'(1));
        bus.aes_busy = 1'b0;
        wait_start("arst_start");
        step();
        chk("arst_pre_lvl", 128'(bus.fifo_level), 128'(3));
        #3 rst_n = 1'b0;
        #1;
        chk("arst_din",   bus.aes_din, 128'(0));
        chk("arst_start", 128'(bus.aes_start), 128'(0));
        chk("arst_lvl",   128'(bus.fifo_level), 128'(0));
        chk("arst_ovf",   128'(bus.overflow), 128'(0));
        chk("arst_to",    128'(bus.timeout_err), 128'(0));
`ifdef AES_BUF_DROP_CNT_EN
        chk("arst_cnt",   128'(bus.drop_cnt), 128'(0));
`endif
        #2 rst_n = 1'b1;
        step();
        step();
        chk("post_rst_start", 128'(bus.aes_start), 128'(0));
        chk("post_rst_lvl",   128'(bus.fifo_level), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_block_buffer.md
Name: aes_block_buffer

Overview:
- Downstream stage of the light-sensor ADC front end.
- Captures each 128-bit sample block presented on data128/data128_en into a small FIFO.
- Issues blocks one at a time to the AES encryption core using a start/busy/done handshake.
- Absorbs bursts while the core is busy, counts dropped blocks, and flags a hung core with a watchdog.

Parameters:
DEPTH, 4, FIFO depth in 128-bit entries; must be a power of 2, minimum 2.
ADDR_W, 2, log2(DEPTH); must match DEPTH.
TIMEOUT, 1024, maximum cycles from aes_start to aes_done before a timeout error is declared.
TO_W, 11, counter width; must hold TIMEOUT.

Ports:
sclk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset; asserts immediately, releases synchronously to sclk.
data128  in  128  sample block from the ADC packer.
data128_en  in  1  one-cycle strobe; data128 is valid in that cycle.
aes_din  out  128  block presented to the AES core.
aes_start  out  1  one-cycle launch pulse; aes_din is valid from this cycle until the next launch.
aes_busy  in  1  AES core busy level.
aes_done  in  1  AES core one-cycle completion pulse.
fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
overflow  out  1  sticky flag: a block was dropped.
timeout_err  out  1  sticky flag: watchdog expired.
clr_err  in  1  synchronous clear of overflow, timeout_err and the drop counter.

Behaviour:
- Reset values: aes_din=0, aes_start=0, fifo_level=0, overflow=0, timeout_err=0; FIFO pointers 0; FSM in IDLE.
- FIFO:
  - Read and write pointers are ADDR_W+1 bits; empty when equal, full when only the MSB differs.
  - A write occurs on data128_en when not full.
  - data128_en while full: block dropped, overflow set. The drop decision uses the pre-edge full flag, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: both happen and fifo_level is unchanged.
  - Pointers wrap naturally modulo 2*DEPTH.
- FSM states:
  - IDLE:
    - Move to LAUNCH when FIFO is non-empty and aes_busy=0.
    - If aes_busy=1, stay in IDLE.
  - LAUNCH (one cycle):
    - aes_din is loaded from the FIFO head, aes_start=1, pop the FIFO.
    - Clear the watchdog counter, then go to WAIT.
  - WAIT:
    - The watchdog counter increments every cycle.
    - aes_done=1 returns to IDLE.
    - Counter reaching TIMEOUT-1 without aes_done: set timeout_err, return to IDLE; the block is considered lost.
    - aes_done in the same cycle as expiry counts as success, and timeout_err is not set.
- aes_done outside WAIT is ignored.
- Latency, with FIFO empty, FSM in IDLE and aes_busy=0:
  - data128_en in cycle N → FIFO written at the end of N.
  - IDLE sees non-empty in N+1.
  - aes_start=1 with aes_din valid in cycle N+2.
- Back-to-back throughput: one block per (3 + core latency) cycles minimum.
- clr_err has priority over a same-cycle set of overflow or timeout_err; the flags end up cleared.
- Reset mid-operation clears the FIFO contents and aborts any WAIT; a block already issued to the core is not tracked.

Optional Feature:
- Macro: AES_BUF_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0], which increments per dropped block and saturates at 16'hFFFF.
  - Cleared by reset or clr_err; clr_err wins over a same-cycle increment.
- Undefined: the port and its logic are absent; overflow flag only.

Decomposition:
- Shared package aes_buf_pkg holds:
  - the FSM state encoding (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2);
  - the block width constant BLK_W=128;
  - the drop counter width DROP_W=16.
- One sub-module, blk_fifo:
  - parameterised synchronous FIFO, width BLK_W, depth DEPTH;
  - ports push, pop, din, dout, full, empty, level.
- The top module holds the FSM, watchdog and error flags.

Test Plan:
- Single block: reset, then data128=128'h0123…CDEF strobed in cycle N with aes_busy=0 → aes_start pulse in N+2 with aes_din=128'h0123…CDEF; fifo_level goes 1 then 0.
- Burst: 4 strobes on consecutive cycles while the core holds busy=1 → fifo_level=4, no overflow; after busy falls and 4 done pulses, 4 launches carry the blocks in order.
- Overflow: 5 strobes with busy=1 and DEPTH=4 → 5th block dropped, overflow=1, drop_cnt=1 (macro on); the 4 earlier blocks are delivered intact.
- Timeout: launch, then never pulse aes_done → timeout_err=1 exactly TIMEOUT cycles after aes_start; FSM returns to IDLE and launches the next queued block.
- Done at expiry: aes_done in the final watchdog cycle → timeout_err stays 0.
- Clear/reset priority:
  - clr_err in the same cycle as an overflow drop → overflow=0.
  - Async rst_n low during WAIT → all outputs return to reset values immediately.
